div_share: RTL and testbench
============================

# div_share

Round-robin arbiter and sequencer that shares one pipelined signed divider (latency LAT, one issue per cycle) among NREQ requesters in the dvp datapath. It grants one request per cycle, registers the operands into the divider and tracks requester ID and divide-by-zero status in a tag pipe aligned to the divider latency. Each quotient is routed back to its originating requester. A global enable stalls the arbiter, the tag pipe and the divider clock enable together.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 26, dividend width
- VW, 26, divisor width
- QW, 26, quotient width
- LAT, 27, divider latency vin->vout in enabled cycles; must equal divider QW+1
- IW, $clog2(NREQ), requester ID width (localparam)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high; the top level drives the divider rst_n from ~rst
- en  in  1  global enable; 0 freezes all state
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  grant/accept; one-hot or zero
- req_dividend  in  NREQ*DW  packed dividends; requester k at [k*DW +: DW]
- req_divisor  in  NREQ*VW  packed divisors; requester k at [k*VW +: VW]
- rsp_valid  out  NREQ  one-cycle result pulse to the owning requester
- rsp_quotient  out  QW  shared result bus, valid with rsp_valid
- rsp_dz  out  1  divisor was zero; valid with rsp_valid
- div_cke  out  1  divider clock enable, equal to en
- div_vin  out  1  divider input valid (registered)
- div_dividend  out  DW  divider dividend (registered)
- div_divisor  out  VW  divider divisor (registered)
- div_quotient  in  QW  divider quotient
- div_vout  in  1  divider output valid
- busy  out  1  any operation is in issue register or tag pipe
- err  out  1  sticky: div_vout disagreed with tag-pipe valid

## Operation
- Arbitration, combinational from req_valid, ptr and en:
  - Grant the first requester with req_valid=1, searching ptr+1, ptr+2, … modulo NREQ.
  - req_ready is asserted only on that bit, and only when en=1.
  - req_ready never depends on itself.
- Transfer occurs when req_valid[k] & req_ready[k]. On transfer:
  - ptr<=k.
  - Issue register loads: vin=1, operands of k, tag {id=k, dz=(divisor==0)}.
- No transfer with en=1: issue register vin<=0, operands hold.
- Tag pipe: LAT stages of {valid, id, dz}. Stage 0 is fed from the issue register and shifts only when en=1. The last stage aligns with div_vout.
- Response register, updated only when en=1:
  - rsp_valid <= onehot(id) & {NREQ{tag_last.valid}}.
  - rsp_quotient <= dz ? {QW{1'b1}} : div_quotient.
  - rsp_dz <= tag_last.dz & tag_last.valid.
  - When en=1 and there is no valid tag, rsp_valid<=0, and rsp_quotient and rsp_dz hold.
- en=0:
  - rsp_valid<=0, div_cke=0.
  - ptr, issue register, tag pipe and rsp data hold.
  - The divider's held vout is not re-emitted.
- err is set when en=1 and div_vout != tag_last.valid. It clears only on rst.
- busy = issue.vin | OR of all tag-pipe valid bits.
- A divide-by-zero request is still issued, to keep the pipe uniform; the divider output is discarded.
- Reset values:
  - req_ready and rsp_valid are 0 while rst=1.
  - div_vin=0, div_dividend=0, div_divisor=0.
  - rsp_quotient=0, rsp_dz=0, busy=0, err=0.
  - Tag pipe is cleared.
  - ptr=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: all in-flight results are dropped and no rsp_valid is produced for them.

## Timing
- Transfer in cycle T → div_vin=1 in T+1 → div_vout=1 in T+1+LAT → rsp_valid in T+2+LAT, i.e. LAT+2 enabled cycles.
- Each en=0 cycle adds one cycle to the latency.
- Throughput: one transfer per enabled cycle with no bubbles, sustained across requester switches.
- Fairness: with all NREQ requesting continuously, each is granted exactly once every NREQ cycles.
- A requester may hold req_valid with changing operands. The operands are sampled only in the transfer cycle.
- Results return in issue order. Two rsp_valid bits are never high in the same cycle.

## Test plan
- Single request: req0 with 100/7, LAT=27. Required: transfer at T, rsp_valid=4'b0001 at T+29, quotient 14, rsp_dz=0, busy low at T+30.
- Full load: all 4 requesting for 40 cycles, requester k using dividend 1000+k, divisor k+1.
  - Grants cycle 0,1,2,3,0,…
  - Responses match issue order with correct quotients, e.g. 1003/4=250.
  - err stays 0.
- Divide by zero: req2 with 55/0. Required: rsp_valid[2]=1, rsp_dz=1, rsp_quotient=26'h3FFFFFF, latency unchanged.
- Stall: en=0 for 5 cycles mid-stream.
  - No rsp_valid and no req_ready during the stall.
  - Latency extends by exactly 5.
  - No duplicated or lost results.
- Reset mid-flight: rst for 1 cycle at 10 cycles after 3 issues.
  - No rsp_valid pulses for the dropped operations.
  - All outputs at reset values; ptr back at NREQ-1; the next request from req0 is granted first.
- Error detection: inject a spurious div_vout from the bench. Required: err=1 one cycle later, and it stays set until rst.

Source files
------------

// File: rtl/div_share.sv
//============================================================================
// Module   : div_share
// Brief    : Round-robin sharing of one pipelined signed divider among
//            NREQ requesters, with an ID/divide-by-zero tag pipe.
// Revision : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_share #(
  parameter int NREQ = 4,
  parameter int DW   = 26,
  parameter int VW   = 26,
  parameter int QW   = 26,
  parameter int LAT  = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_dividend,
  input  logic [NREQ*VW-1:0] req_divisor,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [QW-1:0]      rsp_quotient,
  output logic               rsp_dz,
  output logic               div_cke,
  output logic               div_vin,
  output logic [DW-1:0]      div_dividend,
  output logic [VW-1:0]      div_divisor,
  input  logic [QW-1:0]      div_quotient,
  input  logic               div_vout,
  output logic               busy,
  output logic               err
);

  localparam int              IW    = $clog2(NREQ);
  localparam logic [NREQ-1:0] C_ONE = NREQ'(1);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_gid;
  logic          w_found;
  logic          w_xfer;
  logic [VW-1:0] w_divisor;
  logic [DW-1:0] w_dividend;

  logic [IW-1:0] r_iss_id;
  logic          r_iss_dz;

  logic [LAT-1:0] r_tv;
  logic [LAT-1:0] r_tdz;
  logic [IW-1:0]  r_tid [LAT];

  // First valid requester after the last granted one, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      logic [IW-1:0] v_idx;
      v_idx = IW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gid   = v_idx;
      end
    end
  end

  assign w_xfer     = w_found & en & ~rst;
  assign req_ready  = w_xfer ? (C_ONE << w_gid) : '0;
  assign w_dividend = req_dividend[w_gid*DW +: DW];
  assign w_divisor  = req_divisor[w_gid*VW +: VW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= IW'(NREQ - 1);
      div_vin      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      r_iss_id     <= '0;
      r_iss_dz     <= 1'b0;
    end else if (en) begin
      if (w_xfer) begin
        r_ptr        <= w_gid;
        div_vin      <= 1'b1;
        div_dividend <= w_dividend;
        div_divisor  <= w_divisor;
        r_iss_id     <= w_gid;
        r_iss_dz     <= (w_divisor == '0);
      end else begin
        div_vin <= 1'b0;
      end
    end
  end

  // Tag pipe mirrors the divider latency so the last stage lines up with div_vout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv  <= '0;
      r_tdz <= '0;
      for (int i = 0; i < LAT; i++) r_tid[i] <= '0;
    end else if (en) begin
      r_tv     <= {r_tv[LAT-2:0], div_vin};
      r_tdz    <= {r_tdz[LAT-2:0], r_iss_dz};
      r_tid[0] <= r_iss_id;
      for (int i = 1; i < LAT; i++) r_tid[i] <= r_tid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= '0;
      rsp_quotient <= '0;
      rsp_dz       <= 1'b0;
      err          <= 1'b0;
    end else if (en) begin
      rsp_valid <= r_tv[LAT-1] ? (C_ONE << r_tid[LAT-1]) : '0;
      if (r_tv[LAT-1]) begin
        rsp_quotient <= r_tdz[LAT-1] ? {QW{1'b1}} : div_quotient;
        rsp_dz       <= r_tdz[LAT-1];
      end
      if (div_vout != r_tv[LAT-1]) err <= 1'b1;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign div_cke = en;
  assign busy    = div_vin | (|r_tv);

endmodule

`default_nettype wire

// File: tb/tb_div_share.sv
//============================================================================
// Module   : tb_div_share
// Brief    : Randomised self-checking bench for div_share with a divider model
//            and a transaction-level scoreboard.
// Revision : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_share;

  localparam int NREQ = 4;
  localparam int DW   = 26;
  localparam int VW   = 26;
  localparam int QW   = 26;
  localparam int LAT  = 27;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_dividend;
  logic [NREQ*VW-1:0] req_divisor;
  logic [NREQ-1:0]    rsp_valid;
  logic [QW-1:0]      rsp_quotient;
  logic               rsp_dz;
  logic               div_cke;
  logic               div_vin;
  logic [DW-1:0]      div_dividend;
  logic [VW-1:0]      div_divisor;
  logic [QW-1:0]      div_quotient;
  logic               div_vout;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  div_share #(.NREQ(NREQ), .DW(DW), .VW(VW), .QW(QW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_dz(rsp_dz),
    .div_cke(div_cke), .div_vin(div_vin),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_vout(div_vout),
    .busy(busy), .err(err)
  );

  // Behavioural divider: LAT enabled cycles, garbage quotient on zero divisor.
  logic           inj;
  logic [LAT-1:0] m_v;
  logic [QW-1:0]  m_q [LAT];

  always @(posedge clk) begin
    if (rst) begin
      m_v <= '0;
    end else if (div_cke) begin
      m_v    <= {m_v[LAT-2:0], div_vin};
      m_q[0] <= (div_divisor == '0) ? QW'(26'h0ABCDE)
                                    : QW'($signed(div_dividend) / $signed(div_divisor));
      for (int i = 1; i < LAT; i++) m_q[i] <= m_q[i-1];
    end
  end

  assign div_quotient = m_q[LAT-1];
  assign div_vout     = m_v[LAT-1] | inj;

  typedef struct {
    int          id;
    logic [QW-1:0] q;
    logic        dz;
    longint      due;
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 mptr;
  longint             en_edges;
  logic               prev_en, prev_rst, prev_cause;
  logic [QW-1:0]      last_q;
  logic               last_dz;
  logic               exp_err;
  logic [NREQ-1:0]    vld;
  logic [NREQ*DW-1:0] dvd;
  logic [NREQ*VW-1:0] dvs;
  logic               inj_req;
  int                 gcnt [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check the grant.
  task automatic step(input logic e, input logic r);
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] exp_ready;
    logic            tl;
    logic            exp_vin;
    int              gk;
    @(negedge clk);
    if (prev_rst) begin
      last_q  = '0;
      last_dz = 1'b0;
      exp_err = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_quotient", rsp_quotient, 0);
      check("rst_rsp_dz", rsp_dz, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_div_vin", div_vin, 0);
      check("rst_div_dividend", div_dividend, 0);
      check("rst_div_divisor", div_divisor, 0);
    end else begin
      if (prev_en) en_edges++;
      if (prev_cause) exp_err = 1'b1;
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].due == en_edges) begin
        exp_rv  = NREQ'(1) << sb[0].id;
        last_q  = sb[0].q;
        last_dz = sb[0].dz;
        void'(sb.pop_front());
      end
      exp_vin = 1'b0;
      foreach (sb[i]) if (sb[i].due - en_edges == LAT + 1) exp_vin = 1'b1;
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_quotient", rsp_quotient, last_q);
      check("rsp_dz", rsp_dz, last_dz);
      check("busy", busy, sb.size() != 0);
      check("div_vin", div_vin, exp_vin);
      check("err", err, exp_err);
    end
    tl = 1'b0;
    foreach (sb[i]) if (sb[i].due - en_edges == 1) tl = 1'b1;

    en           = e;
    rst          = r;
    req_valid    = vld;
    req_dividend = dvd;
    req_divisor  = dvs;
    inj          = inj_req;
    #1;
    exp_ready = '0;
    gk = -1;
    if (e && !r) begin
      for (int i = 1; i <= NREQ; i++) begin
        int j = (mptr + i) % NREQ;
        if (gk < 0 && vld[j]) gk = j;
      end
    end
    if (gk >= 0) exp_ready = NREQ'(1) << gk;
    check("req_ready", req_ready, exp_ready);
    if (gk >= 0) begin
      exp_t t;
      int a, b;
      a     = int'($signed(dvd[gk*DW +: DW]));
      b     = int'($signed(dvs[gk*VW +: VW]));
      t.id  = gk;
      t.dz  = (b == 0);
      t.q   = t.dz ? {QW{1'b1}} : QW'(a / b);
      t.due = en_edges + LAT + 2;
      sb.push_back(t);
      mptr = gk;
    end
    if (r) begin
      sb.delete();
      mptr = NREQ - 1;
    end
    prev_cause = inj_req && e && !r && !tl;
    prev_en    = e;
    prev_rst   = r;
  endtask

  task automatic idle(input int n);
    vld = '0;
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++) begin
      int a, b;
      a = int'($urandom_range(0, 2000000)) - 1000000;
      b = int'($urandom_range(0, 200)) - 100;
      dvd[k*DW +: DW] = DW'(a);
      dvs[k*VW +: VW] = VW'(b);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inj = 1'b0;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    vld = '0; dvd = '0; dvs = '0; inj_req = 1'b0;
    prev_en = 1'b0; prev_rst = 1'b1; prev_cause = 1'b0;
    mptr = NREQ - 1; en_edges = 0;
    last_q = '0; last_dz = 1'b0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b1);

    // Single request 100/7
    vld = 4'b0001;
    dvd[0 +: DW] = DW'(100);
    dvs[0 +: VW] = VW'(7);
    step(1'b1, 1'b0);
    idle(32);
    check("q_100_7", rsp_quotient, 14);
    check("dz_100_7", rsp_dz, 0);

    // Full load with fixed operands
    for (int k = 0; k < NREQ; k++) begin
      dvd[k*DW +: DW] = DW'(1000 + k);
      dvs[k*VW +: VW] = VW'(k + 1);
      gcnt[k] = 0;
    end
    vld = '1;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) gcnt[k]++;
    end
    idle(32);
    for (int k = 0; k < NREQ; k++) check($sformatf("fair_%0d", k), gcnt[k], 10);

    // Divide by zero on requester 2
    vld = 4'b0100;
    dvd[2*DW +: DW] = DW'(55);
    dvs[2*VW +: VW] = '0;
    step(1'b1, 1'b0);
    idle(32);
    check("dz_quotient", rsp_quotient, 26'h3FFFFFF);
    check("dz_flag", rsp_dz, 1);

    // Five-cycle stall in the middle of a stream
    vld = '1;
    for (int c = 0; c < 10; c++) begin rand_ops(); step(1'b1, 1'b0); end
    repeat (5) begin rand_ops(); step(1'b0, 1'b0); end
    for (int c = 0; c < 10; c++) begin rand_ops(); step(1'b1, 1'b0); end
    idle(35);

    // Random traffic with random enable
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      vld = NREQ'($urandom);
      step($urandom_range(0, 9) != 0, 1'b0);
    end
    idle(40);

    // Reset with three operations in flight
    vld = 4'b0111;
    repeat (3) begin rand_ops(); step(1'b1, 1'b0); end
    idle(10);
    step(1'b1, 1'b1);
    vld = '1;
    rand_ops();
    step(1'b1, 1'b0);
    check("first_after_rst", req_ready, 4'b0001);
    idle(35);

    // Spurious divider output with an empty pipe
    inj_req = 1'b1;
    step(1'b1, 1'b0);
    inj_req = 1'b0;
    idle(6);
    check("err_sticky", err, 1);
    step(1'b1, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
